// File: rtl/clock_period_meter_pkg.sv
// Shared definitions for the clock period meter: measurement FSM states and
// the default stall timeout (one second at the board clock).
package clock_period_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2
  } meter_state_e;

  localparam int unsigned BOARD_CLK_HZ    = 32'd100_000_000;
  localparam int unsigned DEFAULT_TIMEOUT = BOARD_CLK_HZ;

endpackage

// File: rtl/clock_period_meter_sync_2ff.sv
// Generic 1-bit two-flop synchronizer with synchronous reset; also suitable
// for debouncer front ends on button inputs.
module clock_period_meter_sync_2ff (
  input  logic clk_in,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Two back-to-back flops give the first stage a full cycle to resolve.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/clock_period_meter.sv
// Measures the period of a slow asynchronous waveform in clk_in cycles and
// reports it on a valid/ready output with overrun and stall-timeout pulses.
module clock_period_meter
  import clock_period_meter_pkg::*;
#(
  parameter int unsigned CNT_W   = 32'd32,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             enable,
  output logic             rise_tick,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  input  logic             period_ready,
  output logic             overrun,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LIM  = CNT_W'(TIMEOUT);

  logic         sync_s;
  logic         prev_r;
  logic         rise_s;
  meter_state_e state_r;
  meter_state_e state_nx_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nx_s;
  logic         load_s;
  logic         tmo_s;
  logic         rise_tick_r;
  logic [CNT_W-1:0] period_r;
  logic         period_valid_r;
  logic         overrun_r;
  logic         timeout_r;

  clock_period_meter_sync_2ff u_sync (
    .clk_in (clk_in),
    .rst    (rst),
    .d      (sig_in),
    .q      (sync_s)
  );

  assign rise_s = sync_s & ~prev_r;

  // Edge register: previous synchronized sample and the rise pulse.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      prev_r      <= 1'b0;
      rise_tick_r <= 1'b0;
    end else begin
      prev_r      <= sync_s;
      rise_tick_r <= rise_s;
    end
  end

  // FSM state and period counter.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
    end
  end

  // Next state: enable low overrides everything; a rise beats the timeout.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    load_s     = 1'b0;
    tmo_s      = 1'b0;
    if (!enable) begin
      state_nx_s = ST_IDLE;
      cnt_nx_s   = CNT_ZERO;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nx_s = ST_ARM;
          cnt_nx_s   = CNT_ZERO;
        end
        ST_ARM: begin
          if (rise_s) begin
            state_nx_s = ST_MEASURE;
            cnt_nx_s   = CNT_ONE;
          end else begin
            cnt_nx_s   = CNT_ZERO;
          end
        end
        ST_MEASURE: begin
          if (rise_s) begin
            load_s     = 1'b1;
            cnt_nx_s   = CNT_ONE;
          end else if (cnt_r == CNT_LIM) begin
            tmo_s      = 1'b1;
            cnt_nx_s   = CNT_ZERO;
            state_nx_s = ST_ARM;
          end else begin
            cnt_nx_s   = cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_nx_s = ST_IDLE;
          cnt_nx_s   = CNT_ZERO;
        end
      endcase
    end
  end

  // Result register with handshake; a load in a transfer cycle is not an overrun.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      period_r       <= CNT_ZERO;
      period_valid_r <= 1'b0;
      overrun_r      <= 1'b0;
      timeout_r      <= 1'b0;
    end else begin
      timeout_r <= tmo_s;
      overrun_r <= load_s & period_valid_r & ~period_ready;
      if (load_s) begin
        period_r       <= cnt_r;
        period_valid_r <= 1'b1;
      end else if (period_valid_r && period_ready) begin
        period_valid_r <= 1'b0;
      end
    end
  end

  assign rise_tick    = rise_tick_r;
  assign period       = period_r;
  assign period_valid = period_valid_r;
  assign overrun      = overrun_r;
  assign timeout      = timeout_r;

endmodule

// File: tb/tb_clock_period_meter.sv
// Bench for clock_period_meter: elapsed-time reference model compared every
// cycle, directed scenarios with literal expectations, and a random soak.
module tb_clock_period_meter;

  localparam int CNT_W   = 32;
  localparam int TMO     = 50;
  localparam int M_OFF   = 0;
  localparam int M_ARMED = 1;
  localparam int M_MEAS  = 2;

  logic clk_in       = 1'b0;
  logic rst          = 1'b1;
  logic sig_in       = 1'b0;
  logic enable       = 1'b0;
  logic period_ready = 1'b0;
  logic             rise_tick;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             overrun;
  logic             timeout;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: synchronizer delay line plus time-since-last-rise bookkeeping.
  logic   d1 = 1'b0, d2 = 1'b0, d3 = 1'b0;
  int     mode = M_OFF;
  longint cyc = 0, t0 = 0;
  logic   m_tick = 1'b0, m_ovr = 1'b0, m_tmo = 1'b0, m_valid = 1'b0;
  longint m_period = 0;
  logic   rise_e, m_load;
  longint m_res;
  int     rise_cnt = 0, tmo_cnt = 0, res_cnt = 0, dut_ovr_cnt = 0;
  longint last_res = 0, last_rise_cyc = 0, last_tmo_cyc = 0;
  int     results[$];

  clock_period_meter #(.CNT_W(CNT_W), .TIMEOUT(TMO)) dut (
    .clk_in       (clk_in),
    .rst          (rst),
    .sig_in       (sig_in),
    .enable       (enable),
    .rise_tick    (rise_tick),
    .period       (period),
    .period_valid (period_valid),
    .period_ready (period_ready),
    .overrun      (overrun),
    .timeout      (timeout)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk_in) begin
    cyc++;
    rise_e = d2 & ~d3;
    m_load = 1'b0;
    m_res  = 0;
    if (rst) begin
      d1 = 1'b0; d2 = 1'b0; d3 = 1'b0;
      mode = M_OFF;
      m_tick = 1'b0; m_ovr = 1'b0; m_tmo = 1'b0; m_valid = 1'b0; m_period = 0;
    end else begin
      m_tick = rise_e;
      m_ovr  = 1'b0;
      m_tmo  = 1'b0;
      if (!enable) mode = M_OFF;
      else if (mode == M_OFF) mode = M_ARMED;
      else if (mode == M_ARMED) begin
        if (rise_e) begin mode = M_MEAS; t0 = cyc; end
      end else begin
        if (rise_e) begin m_load = 1'b1; m_res = cyc - t0; t0 = cyc; end
        else if (cyc - t0 == TMO) begin m_tmo = 1'b1; mode = M_ARMED; end
      end
      if (m_load) begin
        m_ovr    = m_valid & ~period_ready;
        m_valid  = 1'b1;
        m_period = m_res;
      end else if (m_valid && period_ready) begin
        m_valid = 1'b0;
      end
      d3 = d2; d2 = d1; d1 = sig_in;
    end
    if (m_tick) begin rise_cnt++; last_rise_cyc = cyc; end
    if (m_tmo)  begin tmo_cnt++;  last_tmo_cyc  = cyc; end
    if (m_load) begin res_cnt++; last_res = m_res; results.push_back(int'(m_res)); end
    #1;
    chk("rise_tick",    64'(rise_tick),    64'(m_tick));
    chk("period",       64'(period),       64'(m_period));
    chk("period_valid", 64'(period_valid), 64'(m_valid));
    chk("overrun",      64'(overrun),      64'(m_ovr));
    chk("timeout",      64'(timeout),      64'(m_tmo));
    if (overrun === 1'b1) dut_ovr_cnt++;
  end

  task automatic drive_periodic(input int per, input int n);
    for (int i = 0; i < n; i++) begin
      sig_in = 1'b1;
      repeat (per / 2) @(negedge clk_in);
      sig_in = 1'b0;
      repeat (per - per / 2) @(negedge clk_in);
    end
  endtask

  task automatic pulse(input int hi);
    sig_in = 1'b1;
    repeat (hi) @(negedge clk_in);
    sig_in = 1'b0;
  endtask

  // Toggles on a 18.5-cycle grid with bounded jitter, never on a rising clock edge.
  task automatic drive_async(input int n_rises);
    longint base, t;
    int j;
    base = longint'($time) + 200;
    for (int k = 1; k <= 2 * n_rises; k++) begin
      j = int'($urandom_range(0, 8)) - 4;
      t = base + longint'(k) * 185 + longint'(j);
      if (t % 10 == 5) t = t + 1;
      #(t - longint'($time));
      sig_in = ~sig_in;
    end
  endtask

  task automatic wait_rises(input int n, input int budget);
    int tgt, k;
    tgt = rise_cnt + n;
    k = 0;
    while (rise_cnt < tgt && k < budget) begin
      @(negedge clk_in);
      k++;
    end
    chk("wait_rises", 64'(rise_cnt >= tgt), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, vectors %0d", vectors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r0, t0c, hold, n;
    longint sum;

    repeat (3) @(negedge clk_in);
    chk("rst_rise_tick", 64'(rise_tick),    64'd0);
    chk("rst_period",    64'(period),       64'd0);
    chk("rst_valid",     64'(period_valid), 64'd0);
    chk("rst_overrun",   64'(overrun),      64'd0);
    chk("rst_timeout",   64'(timeout),      64'd0);
    rst = 1'b0;
    enable = 1'b1;
    period_ready = 1'b1;

    // Divider loopback, DIV=4 then DIV=10.
    results.delete();
    drive_periodic(4, 12);
    repeat (5) @(negedge clk_in);
    chk("div4_count", 64'(results.size() >= 10), 64'd1);
    for (int i = 1; i < results.size(); i++) chk("div4_period", 64'(results[i]), 64'd4);
    results.delete();
    drive_periodic(10, 8);
    repeat (5) @(negedge clk_in);
    chk("div10_count", 64'(results.size() >= 6), 64'd1);
    for (int i = 1; i < results.size(); i++) chk("div10_period", 64'(results[i]), 64'd10);

    // Asynchronous 37-cycle input with random phase.
    results.delete();
    drive_async(22);
    repeat (5) @(negedge clk_in);
    n = results.size();
    chk("async_count", 64'(n >= 20), 64'd1);
    sum = 0;
    for (int i = (n >= 20) ? n - 20 : 0; i < n; i++) begin
      chk("async_range", 64'(results[i] >= 36 && results[i] <= 38), 64'd1);
      sum += results[i];
    end
    if (n >= 20) chk("async_avg", 64'((sum + 10) / 20), 64'd37);

    // Backpressure: three results with ready low give two overruns.
    period_ready = 1'b1;
    fork
      drive_periodic(8, 9);
      begin
        wait_rises(1, 60);
        repeat (2) @(negedge clk_in);
        period_ready = 1'b0;
        r0 = dut_ovr_cnt;
        wait_rises(3, 60);
        @(negedge clk_in);
        chk("bp_overruns",   64'(dut_ovr_cnt - r0), 64'd2);
        chk("bp_period",     64'(period),           64'd8);
        chk("bp_valid_held", 64'(period_valid),     64'd1);
        period_ready = 1'b1;
        @(negedge clk_in);
        period_ready = 1'b0;
        chk("bp_valid_drop", 64'(period_valid), 64'd0);
        period_ready = 1'b1;
      end
    join

    // Timeout after a lone edge, then re-arm and measure 20.
    repeat (60) @(negedge clk_in);
    t0c = tmo_cnt;
    r0  = res_cnt;
    pulse(3);
    repeat (70) @(negedge clk_in);
    chk("tmo_count",     64'(tmo_cnt - t0c),                 64'd1);
    chk("tmo_distance",  64'(last_tmo_cyc - last_rise_cyc),  64'd50);
    chk("tmo_no_result", 64'(res_cnt - r0),                  64'd0);
    pulse(3);
    repeat (17) @(negedge clk_in);
    pulse(3);
    repeat (6) @(negedge clk_in);
    chk("tmo_rearm_results", 64'(res_cnt - r0), 64'd1);
    chk("tmo_rearm_period",  64'(last_res),      64'd20);

    // Boundary: edges exactly TIMEOUT apart.
    repeat (60) @(negedge clk_in);
    t0c = tmo_cnt;
    r0  = res_cnt;
    for (int i = 0; i < 3; i++) begin
      pulse(3);
      if (i < 2) repeat (47) @(negedge clk_in);
    end
    repeat (6) @(negedge clk_in);
    chk("bnd_results", 64'(res_cnt - r0),   64'd2);
    chk("bnd_period",  64'(last_res),       64'd50);
    chk("bnd_no_tmo",  64'(tmo_cnt - t0c),  64'd0);

    // Enable drop mid-measure keeps the pending result consumable.
    period_ready = 1'b0;
    drive_periodic(12, 3);
    pulse(3);
    repeat (5) @(negedge clk_in);
    r0 = res_cnt;
    enable = 1'b0;
    pulse(6);
    repeat (10) @(negedge clk_in);
    chk("dis_no_result",  64'(res_cnt - r0),  64'd0);
    chk("dis_valid_kept", 64'(period_valid),  64'd1);
    period_ready = 1'b1;
    @(negedge clk_in);
    period_ready = 1'b0;
    chk("dis_consume", 64'(period_valid), 64'd0);
    enable = 1'b1;
    r0 = res_cnt;
    drive_periodic(12, 3);
    repeat (4) @(negedge clk_in);
    chk("reen_results", 64'(res_cnt - r0), 64'd2);
    chk("reen_period",  64'(last_res),     64'd12);

    // Reset mid-measure clears everything on the next cycle.
    pulse(3);
    repeat (5) @(negedge clk_in);
    rst = 1'b1;
    @(negedge clk_in);
    chk("rstm_rise_tick", 64'(rise_tick),    64'd0);
    chk("rstm_period",    64'(period),       64'd0);
    chk("rstm_valid",     64'(period_valid), 64'd0);
    chk("rstm_overrun",   64'(overrun),      64'd0);
    chk("rstm_timeout",   64'(timeout),      64'd0);
    rst = 1'b0;
    r0 = res_cnt;
    drive_periodic(12, 2);
    repeat (4) @(negedge clk_in);
    chk("post_rst_results", 64'(res_cnt - r0), 64'd1);
    chk("post_rst_period",  64'(last_res),     64'd12);

    // Random soak: random waveform, backpressure, enable flips, rare resets.
    hold = 0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk_in);
      if (hold == 0) begin
        sig_in = ~sig_in;
        hold = int'($urandom_range(0, 29));
      end else begin
        hold--;
      end
      period_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) == 0) enable = ~enable;
      rst = ($urandom_range(0, 299) == 0);
    end
    rst = 1'b0;
    repeat (5) @(negedge clk_in);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
